// File: rtl/axi_rom_rd_slave.sv
// axi_rom_rd_slave
//   AXI4 read-only slave in front of a synchronous ROM macro (boot ROM).
//   It handles FIXED/INCR/WRAP bursts with one outstanding transaction.
//   Each beat drives CS/OE/A and waits a configurable ROM latency.
//   Each beat then returns one R beat carrying OKAY, SLVERR or DECERR.
// Ports
//   ACLK, ARESETn                       clock, asynchronous active-low reset
//   ARID/ARADDR/ARLEN/ARSIZE/ARBURST    read address channel payload
//   ARVALID/ARREADY                     read address handshake
//   RID/RDATA/RRESP/RLAST               read data channel payload (registered)
//   RVALID/RREADY                       read data handshake
//   CS/OE/A/DO                          ROM macro interface
module axi_rom_rd_slave #(
  parameter int               ID_W    = 8,
  parameter int               ADDR_W  = 32,
  parameter int               DATA_W  = 32,
  parameter int               ROM_AW  = 12,
  parameter logic [ADDR_W-1:0] BASE   = 32'h0000_0000,
  parameter int               ROM_LAT = 1
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              CS,
  output logic              OE,
  output logic [ROM_AW-1:0] A,
  input  logic [DATA_W-1:0] DO
);

  localparam int BSH    = $clog2(DATA_W / 8);
  localparam int WIN_SH = ROM_AW + BSH;
  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_FETCH, S_RESP} state_t;

  // Beat address outside the ROM window; the offset wraps so addresses below BASE also miss.
  function automatic logic is_decerr(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE;
    return ((off >> WIN_SH) != {ADDR_W{1'b0}});
  endfunction

  function automatic logic [ROM_AW-1:0] word_addr(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE;
    return off[WIN_SH-1:BSH];
  endfunction

  // Whole-burst protocol errors, evaluated once at AR acceptance.
  function automatic logic burst_slverr(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                                        input logic [2:0] size, input logic [1:0] burst);
    logic              err;
    logic [ADDR_W-1:0] lane_mask;
    lane_mask = (ONE_A << size) - ONE_A;
    err = 1'b0;
    if (size > 3'(BSH)) err = 1'b1;
    if (burst == 2'b11) err = 1'b1;
    if (burst == 2'b10) begin
      if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15})) err = 1'b1;
      if ((addr & lane_mask) != {ADDR_W{1'b0}}) err = 1'b1;
    end
    return err;
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                                                  input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] wmask;
    logic [ADDR_W-1:0] res;
    incr  = ONE_A << size;
    wmask = ((({{(ADDR_W-8){1'b0}}, len}) + ONE_A) << size) - ONE_A;
    case (burst)
      2'b00:   res = addr;
      2'b01:   res = addr + incr;
      2'b10:   res = (addr & ~wmask) | ((addr + incr) & wmask);
      default: res = addr + incr;
    endcase
    return res;
  endfunction

  state_t              state_r, state_n;
  logic [2:0]          lat_r, lat_n;
  logic [7:0]          beat_r, beat_n;
  logic [ADDR_W-1:0]   addr_r, addr_n;
  logic [7:0]          len_r, len_n;
  logic [2:0]          size_r, size_n;
  logic [1:0]          burst_r, burst_n;
  logic                berr_r, berr_n;
  logic                arready_r, arready_n;
  logic [ID_W-1:0]     rid_r, rid_n;
  logic [DATA_W-1:0]   rdata_r, rdata_n;
  logic [1:0]          rresp_r, rresp_n;
  logic                rlast_r, rlast_n;
  logic                rvalid_r, rvalid_n;
  logic                cs_r, cs_n;
  logic [ROM_AW-1:0]   a_r, a_n;
  logic                acc_err_s;
  logic                beat_dec_s;
  logic [ADDR_W-1:0]   nxt_s;

  // Next-state and next-output logic for the burst sequencer.
  always_comb begin
    state_n   = state_r;
    lat_n     = lat_r;
    beat_n    = beat_r;
    addr_n    = addr_r;
    len_n     = len_r;
    size_n    = size_r;
    burst_n   = burst_r;
    berr_n    = berr_r;
    arready_n = arready_r;
    rid_n     = rid_r;
    rdata_n   = rdata_r;
    rresp_n   = rresp_r;
    rlast_n   = rlast_r;
    rvalid_n  = rvalid_r;
    cs_n      = cs_r;
    a_n       = a_r;
    acc_err_s  = burst_slverr(ARADDR, ARLEN, ARSIZE, ARBURST);
    beat_dec_s = is_decerr(addr_r);
    nxt_s      = next_addr(addr_r, len_r, size_r, burst_r);
    case (state_r)
      S_INIT: begin
        state_n = S_IDLE;
      end
      S_IDLE: begin
        if (ARVALID && arready_r) begin
          arready_n = 1'b0;
          rid_n     = ARID;
          addr_n    = ARADDR;
          len_n     = ARLEN;
          size_n    = ARSIZE;
          burst_n   = ARBURST;
          berr_n    = acc_err_s;
          beat_n    = 8'd0;
          lat_n     = 3'd0;
          a_n       = word_addr(ARADDR);
          cs_n      = !(is_decerr(ARADDR) || acc_err_s);
          state_n   = S_FETCH;
        end else begin
          arready_n = 1'b1;
        end
      end
      S_FETCH: begin
        // DO is sampled once the ROM has had ROM_LAT edges after A/CS were presented.
        if (lat_r == 3'(ROM_LAT)) begin
          cs_n     = 1'b0;
          rvalid_n = 1'b1;
          rlast_n  = (beat_r == len_r);
          if (beat_dec_s) begin
            rresp_n = 2'b11;
          end else if (berr_r) begin
            rresp_n = 2'b10;
          end else begin
            rresp_n = 2'b00;
          end
          if (beat_dec_s || berr_r) begin
            rdata_n = {DATA_W{1'b0}};
          end else begin
            rdata_n = DO;
          end
          state_n = S_RESP;
        end else begin
          lat_n = lat_r + 3'd1;
        end
      end
      S_RESP: begin
        if (RREADY) begin
          rvalid_n = 1'b0;
          if (rlast_r) begin
            arready_n = 1'b1;
            state_n   = S_IDLE;
          end else begin
            beat_n  = beat_r + 8'd1;
            addr_n  = nxt_s;
            a_n     = word_addr(nxt_s);
            cs_n    = !(is_decerr(nxt_s) || berr_r);
            lat_n   = 3'd0;
            state_n = S_FETCH;
          end
        end else begin
          state_n = S_RESP;
        end
      end
      default: begin
        state_n = S_INIT;
      end
    endcase
  end

  // State and registered-output flops; reset clears every output.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_r   <= S_INIT;
      lat_r     <= 3'd0;
      beat_r    <= 8'd0;
      addr_r    <= {ADDR_W{1'b0}};
      len_r     <= 8'd0;
      size_r    <= 3'd0;
      burst_r   <= 2'd0;
      berr_r    <= 1'b0;
      arready_r <= 1'b0;
      rid_r     <= {ID_W{1'b0}};
      rdata_r   <= {DATA_W{1'b0}};
      rresp_r   <= 2'b00;
      rlast_r   <= 1'b0;
      rvalid_r  <= 1'b0;
      cs_r      <= 1'b0;
      a_r       <= {ROM_AW{1'b0}};
    end else begin
      state_r   <= state_n;
      lat_r     <= lat_n;
      beat_r    <= beat_n;
      addr_r    <= addr_n;
      len_r     <= len_n;
      size_r    <= size_n;
      burst_r   <= burst_n;
      berr_r    <= berr_n;
      arready_r <= arready_n;
      rid_r     <= rid_n;
      rdata_r   <= rdata_n;
      rresp_r   <= rresp_n;
      rlast_r   <= rlast_n;
      rvalid_r  <= rvalid_n;
      cs_r      <= cs_n;
      a_r       <= a_n;
    end
  end

  assign ARREADY = arready_r;
  assign RID     = rid_r;
  assign RDATA   = rdata_r;
  assign RRESP   = rresp_r;
  assign RLAST   = rlast_r;
  assign RVALID  = rvalid_r;
  assign CS      = cs_r;
  assign OE      = cs_r;
  assign A       = a_r;

endmodule
